// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game state sequencer: IDLE/PLAY/PAUSE/OVER, play seconds, difficulty level, bonus window.
// Optional pause feature enabled by defining GAME_PAUSE_EN.
module game_sequencer (
   input  logic       clk_2hz,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       lose,
   input  logic       good,
   output logic [1:0] state,
   output logic       run,
   output logic [9:0] sec,
   output logic [2:0] level,
   output logic       bonus_win
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      PAUSED = 2'd2,
      OVER   = 2'd3
   } state_t;

   localparam logic [9:0] SEC_MAX     = 10'd999;
   localparam logic [5:0] LEV_CNT_MAX = 6'd39;
   localparam logic [2:0] LEVEL_MAX   = 3'd7;

   state_t     st;
   logic       start_q;
   logic       half;
   logic [5:0] lev_cnt;
   logic       start_rise;
   logic       pause_rise;
   logic       bonus_next;

   assign start_rise = start & ~start_q;
   assign state      = st;
   assign run        = (st == PLAY);
   assign bonus_next = (st == PLAY) && ((sec % 10'd30) == 10'd29);

`ifdef GAME_PAUSE_EN
   logic pause_q;

   always_ff @(posedge clk_2hz or posedge rst) begin
      if (rst) pause_q <= 1'b0;
      else     pause_q <= pause;
   end

   assign pause_rise = pause & ~pause_q;
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign pause_rise   = 1'b0;
`endif

   always_ff @(posedge clk_2hz or posedge rst) begin
      if (rst) begin
         st        <= IDLE;
         start_q   <= 1'b0;
         half      <= 1'b0;
         lev_cnt   <= 6'd0;
         sec       <= 10'd0;
         level     <= 3'd0;
         bonus_win <= 1'b0;
      end else begin
         start_q   <= start;
         bonus_win <= bonus_next;
         case (st)
            IDLE: begin
               if (start_rise) begin
                  st      <= PLAY;
                  half    <= 1'b0;
                  lev_cnt <= 6'd0;
                  sec     <= 10'd0;
                  level   <= 3'd0;
               end
            end
            PLAY: begin
               // lose wins over everything: counters and level freeze on that tick
               if (lose) begin
                  st <= OVER;
               end else begin
                  if (pause_rise) st <= PAUSED;
                  half <= ~half;
                  if (half && (sec != SEC_MAX)) sec <= sec + 10'd1;
                  if (good) begin
                     if (level != 3'd0) level <= level - 3'd1;
                     lev_cnt <= 6'd0;
                  end else if (lev_cnt == LEV_CNT_MAX) begin
                     lev_cnt <= 6'd0;
                     if (level != LEVEL_MAX) level <= level + 3'd1;
                  end else begin
                     lev_cnt <= lev_cnt + 6'd1;
                  end
               end
            end
            PAUSED: begin
`ifdef GAME_PAUSE_EN
               if (pause_rise) st <= PLAY;
`else
               st <= IDLE;
`endif
            end
            OVER: begin
               if (start_rise) begin
                  st    <= IDLE;
                  sec   <= 10'd0;
                  level <= 3'd0;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized self-checking bench for game_sequencer against a tick-count reference model.
module tb_game_sequencer;

   logic       clk_2hz = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       lose = 1'b0;
   logic       good = 1'b0;
   logic [1:0] state;
   logic       run;
   logic [9:0] sec;
   logic [2:0] level;
   logic       bonus_win;

   int checks = 0;
   int failures = 0;

   // reference model: sec derives from play ticks, level from ticks since the last level event
   int m_state, m_ticks, m_since, m_level;
   bit m_bonus, m_sq, m_pq;

   game_sequencer dut (
      .clk_2hz  (clk_2hz),
      .rst      (rst),
      .start    (start),
      .pause    (pause),
      .lose     (lose),
      .good     (good),
      .state    (state),
      .run      (run),
      .sec      (sec),
      .level    (level),
      .bonus_win(bonus_win)
   );

   always #5 clk_2hz = ~clk_2hz;

   function automatic int m_sec();
      return (m_ticks / 2 > 999) ? 999 : m_ticks / 2;
   endfunction

   task automatic model_reset();
      m_state = 0; m_ticks = 0; m_since = 0; m_level = 0;
      m_bonus = 0; m_sq = 0; m_pq = 0;
   endtask

   task automatic cycle(input bit s, input bit p, input bit l, input bit g);
      bit sr, pr, nb;
      start = s; pause = p; lose = l; good = g;
      sr = s && !m_sq;
`ifdef GAME_PAUSE_EN
      pr = p && !m_pq;
`else
      pr = 1'b0;
`endif
      nb = (m_state == 1) && (m_sec() % 30 == 29);
      case (m_state)
         0: if (sr) begin m_state = 1; m_ticks = 0; m_since = 0; m_level = 0; end
         1: begin
            if (l) m_state = 3;
            else begin
               if (pr) m_state = 2;
               m_ticks++;
               if (g) begin
                  if (m_level > 0) m_level--;
                  m_since = 0;
               end else begin
                  m_since++;
                  if (m_since == 40) begin
                     m_since = 0;
                     if (m_level < 7) m_level++;
                  end
               end
            end
         end
         2: if (pr) m_state = 1;
         default: if (sr) begin m_state = 0; m_ticks = 0; m_level = 0; end
      endcase
      m_bonus = nb; m_sq = s; m_pq = p;
      @(posedge clk_2hz);
      #1;
   endtask

   task automatic do_reset();
      start = 0; pause = 0; lose = 0; good = 0;
      rst = 1'b1;
      model_reset();
      @(posedge clk_2hz);
      #1;
      rst = 1'b0;
   endtask

   task automatic begin_game();
      do_reset();
      cycle(1, 0, 0, 0);
   endtask

   task automatic test_reset();
      do_reset();
      cycle(1, 0, 0, 0);
      repeat (7) cycle(0, 0, 0, 0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({state, run, sec, level, bonus_win} !== 17'd0) begin
         failures++;
         $display("FAIL reset_async got state=%0d run=%0d sec=%0d level=%0d bonus=%0d exp all 0",
                  state, run, sec, level, bonus_win);
      end
      @(posedge clk_2hz);
      #1;
      rst = 1'b0;
      cycle(0, 0, 0, 0);
      checks++;
      if (state !== 2'd0 || sec !== 10'd0) begin
         failures++;
         $display("FAIL reset_release got state=%0d sec=%0d exp state=0 sec=0", state, sec);
      end
   endtask

   task automatic test_start_count();
      begin_game();
      checks++;
      if (state !== 2'd1 || run !== 1'b1) begin
         failures++;
         $display("FAIL start_to_play got state=%0d run=%0d exp 1 1", state, run);
      end
      repeat (20) cycle(0, 0, 0, 0);
      checks++;
      if (sec !== 10'd10 || level !== 3'd0) begin
         failures++;
         $display("FAIL sec_after_20 got sec=%0d level=%0d exp 10 0", sec, level);
      end
   endtask

   task automatic test_level();
      repeat (60) cycle(0, 0, 0, 0);
      checks++;
      if (sec !== 10'd40 || level !== 3'd2) begin
         failures++;
         $display("FAIL level_after_80 got sec=%0d level=%0d exp 40 2", sec, level);
      end
      repeat (520) cycle(0, 0, 0, 0);
      checks++;
      if (level !== 3'd7 || sec !== 10'd300) begin
         failures++;
         $display("FAIL level_saturate got level=%0d sec=%0d exp 7 300", level, sec);
      end
   endtask

   task automatic test_good_wrap();
      begin_game();
      repeat (159) cycle(0, 0, 0, 0);
      checks++;
      if (level !== 3'd3) begin
         failures++;
         $display("FAIL good_setup_level got=%0d exp=3", level);
      end
      cycle(0, 0, 0, 1);
      checks++;
      if (level !== 3'd2) begin
         failures++;
         $display("FAIL good_at_wrap got=%0d exp=2", level);
      end
      repeat (39) cycle(0, 0, 0, 0);
      checks++;
      if (level !== 3'd2) begin
         failures++;
         $display("FAIL good_cnt_cleared got=%0d exp=2", level);
      end
      cycle(0, 0, 0, 0);
      checks++;
      if (level !== 3'd3) begin
         failures++;
         $display("FAIL good_next_wrap got=%0d exp=3", level);
      end
   endtask

   task automatic test_bonus();
      int highs;
      bit saw59;
      highs = 0;
      saw59 = 0;
      begin_game();
      for (int i = 0; i < 125; i++) begin
         cycle(0, 0, 0, 0);
         if (bonus_win === 1'b1) highs++;
         if (bonus_win === 1'b1 && sec === 10'd59) saw59 = 1;
         checks++;
         if (bonus_win !== m_bonus) begin
            failures++;
            $display("FAIL bonus_cycle%0d got=%0d exp=%0d", i, bonus_win, m_bonus);
         end
      end
      checks++;
      if (highs != 4 || !saw59) begin
         failures++;
         $display("FAIL bonus_count got=%0d saw59=%0d exp=4 saw59=1", highs, saw59);
      end
   endtask

   task automatic test_lose_good();
      logic [9:0] frozen;
      logic [2:0] lvl;
      begin_game();
      repeat (95) cycle(0, 0, 0, 0);
      frozen = sec;
      lvl = level;
      cycle(0, 0, 1, 1);
      checks++;
      if (state !== 2'd3 || level !== lvl || sec !== frozen) begin
         failures++;
         $display("FAIL lose_good got state=%0d level=%0d sec=%0d exp 3 %0d %0d",
                  state, level, sec, lvl, frozen);
      end
      repeat (6) cycle(0, 0, 0, 0);
      checks++;
      if (sec !== frozen || level !== lvl) begin
         failures++;
         $display("FAIL over_frozen got sec=%0d level=%0d exp %0d %0d", sec, level, frozen, lvl);
      end
      cycle(1, 0, 0, 0);
      checks++;
      if (state !== 2'd0 || sec !== 10'd0 || level !== 3'd0) begin
         failures++;
         $display("FAIL over_restart got state=%0d sec=%0d level=%0d exp 0 0 0", state, sec, level);
      end
   endtask

   task automatic test_pause();
      begin_game();
      repeat (10) cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
`ifdef GAME_PAUSE_EN
      checks++;
      if (state !== 2'd2 || sec !== 10'd5 || run !== 1'b0) begin
         failures++;
         $display("FAIL pause_enter got state=%0d sec=%0d run=%0d exp 2 5 0", state, sec, run);
      end
      repeat (10) cycle(0, 0, 1, 0);
      checks++;
      if (state !== 2'd2 || sec !== 10'd5) begin
         failures++;
         $display("FAIL pause_hold got state=%0d sec=%0d exp 2 5", state, sec);
      end
      cycle(0, 1, 0, 0);
      checks++;
      if (state !== 2'd1) begin
         failures++;
         $display("FAIL pause_resume got=%0d exp=1", state);
      end
`else
      repeat (10) cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      checks++;
      if (state !== 2'd1 || sec !== 10'd11) begin
         failures++;
         $display("FAIL pause_ignored got state=%0d sec=%0d exp 1 11", state, sec);
      end
`endif
   endtask

   task automatic test_random();
      bit s, p, l, g;
      begin_game();
      for (int i = 0; i < 500; i++) begin
         s = ($urandom_range(0, 99) < 6);
         p = ($urandom_range(0, 99) < 8);
         l = ($urandom_range(0, 99) < 2);
         g = ($urandom_range(0, 99) < 6);
         cycle(s, p, l, g);
         checks++;
         if (state !== m_state[1:0] || run !== (m_state == 1) || sec !== m_sec() ||
             level !== m_level[2:0] || bonus_win !== m_bonus) begin
            failures++;
            $display("FAIL random_cycle%0d got st=%0d run=%0d sec=%0d lvl=%0d bw=%0d exp st=%0d sec=%0d lvl=%0d bw=%0d",
                     i, state, run, sec, level, bonus_win, m_state, m_sec(), m_level, m_bonus);
         end
         checks++;
         if (state === 2'd2 && !`ifdef GAME_PAUSE_EN 1'b1 `else 1'b0 `endif) begin
            failures++;
            $display("FAIL random_state2 got=%0d exp=not 2", state);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_start_count();
      test_level();
      test_good_wrap();
      test_bonus();
      test_lose_good();
      test_pause();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have port clk_2hz  input  1  game-tick clock, 2 Hz, all state advances on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start  input  1  start/restart button, level, already debounced.
REQ-004 SHALL have port pause  input  1  pause button, level, already debounced.
REQ-005 SHALL have port lose  input  1  game-over flag from the playfield renderer.
REQ-006 SHALL have port good  input  1  bonus-hit flag from the playfield renderer.
REQ-007 SHALL have port state  output  2  0=IDLE, 1=PLAY, 2=PAUSE, 3=OVER.
REQ-008 SHALL have port run  output  1  high only in PLAY; gates tile motion and player movement.
REQ-009 SHALL have port sec  output  10  elapsed play seconds, 0..999.
REQ-010 SHALL have port level  output  3  difficulty level 0..7; drives the tile-speed clock select.
REQ-011 SHALL have port bonus_win  output  1  bonus-colour capture window.

Function
REQ-012 SHALL register start and pause each cycle; start_rise = start & ~start_q, pause_rise = pause & ~pause_q.
REQ-013 IDLE: start_rise -> PLAY; sec, level, half, lev_cnt all cleared on that edge.
REQ-014 PLAY: lose -> OVER (highest priority); else pause_rise -> PAUSE (REQ-026); else stay.
REQ-015 PAUSE: pause_rise -> PLAY; lose ignored; start_rise ignored.
REQ-016 OVER: start_rise -> IDLE, clearing sec and level; otherwise hold all counters.
REQ-017 SHALL use a 1-bit half-tick register that toggles every cycle in PLAY and is frozen in other states.
REQ-018 In PLAY with half==1, sec SHALL increment by 1 and saturate at 999 (no wrap).
REQ-019 SHALL use a 6-bit lev_cnt that counts half-ticks in PLAY from 0 to 39 and wraps to 0; on the wrap, level SHALL increment and saturate at 7.
REQ-020 In PLAY, good SHALL decrement level by 1, floored at 0, and clear lev_cnt; if good coincides with a lev_cnt wrap, only the good action SHALL apply.
REQ-021 If lose and good are both high in PLAY, the state SHALL go to OVER and level SHALL stay unchanged.
REQ-022 bonus_win SHALL be registered, =1 iff state==PLAY and sec%30==29, evaluated on the current sec (one-cycle latency).
REQ-023 run SHALL be combinational: state==PLAY.
REQ-024 sec and level SHALL hold in PAUSE and OVER; state SHALL never take a value outside 0..3.

Reset
REQ-025 On rst: state=IDLE, sec=0, level=0, half=0, lev_cnt=0, bonus_win=0, start_q=0, pause_q=0, run=0; the cycle after rst release behaves as IDLE with no pending edge.

Configuration
REQ-026 Macro GAME_PAUSE_EN compiled in: PAUSE state and pause transitions per REQ-014/015. Compiled out: pause ignored, pause_q not built, state SHALL never equal 2, PLAY exits only on lose.

Verification
REQ-027 Reset, then start high for 1 cycle -> state=1 next edge; after 20 cycles sec=10, level=0.
REQ-028 Run 80 cycles in PLAY -> sec=40, level=2; run 600 cycles total -> level saturates at 7.
REQ-029 level=3, good pulse coinciding with lev_cnt=39 -> level=2, lev_cnt=0.
REQ-030 sec reaches 29 -> bonus_win=1 for exactly 2 cycles; sec=59 -> bonus_win=1 again.
REQ-031 lose and good together in PLAY -> state=3, sec frozen; start pulse -> state=0, sec=0, level=0.
REQ-032 GAME_PAUSE_EN: pause pulse at sec=5 -> state=2, sec stays 5 for 10 cycles; second pulse -> state=1; without the macro the same stimulus leaves state=1 and sec advancing.
